wb_sram_slave: RTL and testbench

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

---
 rtl/wb_sram_slave.sv | 137 +++++++++++++
 tb/tb_wb_sram_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// Wishbone classic single-port SRAM slave with programmable wait states.
// Ports: clk_i/rst_i (sync, active low), adr_i/dat_i/sel_i/we_i/cyc_i/stb_i in; dat_o/ack_o/err_o out.
module wb_sram_slave #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WS    = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;

  logic        in_range_q;
  logic        in_range_d;
  logic        enter_resp;
  logic        wr_en;

  logic [31:0] mem [DEPTH];

  assign in_range_q = (adr_q[29:DEPTH_LOG2] == '0);
  assign in_range_d = (adr_d[29:DEPTH_LOG2] == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    unique case (state_q)
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          adr_d = adr_i;
          dat_d = dat_i;
          sel_d = sel_i;
          we_d  = we_i;
          if (WS == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The _d bundle is used so the zero-wait path commits on the accept edge.
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign wr_en      = rst_i && enter_resp && we_d && in_range_d;

  always_comb begin
    rdata_d = '0;
    if (enter_resp && !we_d && in_range_d) begin
      rdata_d = mem[adr_d[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_d[i]) begin
          mem[adr_d[DEPTH_LOG2-1:0]][8*i +: 8] <= dat_d[8*i +: 8];
        end
      end
    end
  end

  assign ack_o = (state_q == S_RESP) && in_range_q;
  assign err_o = (state_q == S_RESP) && !in_range_q;
  // rdata_q is only loaded on entry to an in-range read response.
  assign dat_o = rdata_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: one instance with one wait state,
// one with zero wait states; scoreboard of expected responses.
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we_s = 1'b0;
  logic        stb = 1'b0;
  logic        cyc1 = 1'b0;
  logic        cyc0 = 1'b0;
  logic [31:0] dat1, dat0;
  logic        ack1, err1, ack0, err0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m1 [int];
  logic [31:0] m0 [int];

  always #5 clk = ~clk;

  wb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat),
    .sel_i(sel), .we_i(we_s), .cyc_i(cyc1), .stb_i(stb),
    .dat_o(dat1), .ack_o(ack1), .err_o(err1)
  );

  wb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat),
    .sel_i(sel), .we_i(we_s), .cyc_i(cyc0), .stb_i(stb),
    .dat_o(dat0), .ack_o(ack0), .err_o(err0)
  );

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  task automatic do_xfer(input bit z, input bit we,
                         input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, input string tag);
    exp_t        e;
    exp_t        g;
    logic [31:0] old;
    int          n;
    int          k;
    bit          inr;
    logic        ra, re;
    logic [31:0] rd;
    k     = int'(a);
    inr   = (a[29:10] == 20'd0);
    e.ack = inr;
    e.err = !inr;
    e.dat = '0;
    if (inr) begin
      old = '0;
      if (z && m0.exists(k)) old = m0[k];
      if (!z && m1.exists(k)) old = m1[k];
      if (we) begin
        if (z) m0[k] = merge(old, d, s);
        else   m1[k] = merge(old, d, s);
      end else begin
        e.dat = old;
      end
    end
    sbq.push_back(e);
    adr  = a;
    wdat = d;
    sel  = s;
    we_s = we;
    stb  = 1'b1;
    if (z) cyc0 = 1'b1;
    else   cyc1 = 1'b1;
    @(posedge clk); #1;
    // Disturb the bus after acceptance; latched values must be used.
    adr  = ~a;
    wdat = ~d;
    stb  = 1'b0;
    n = 0;
    while (!(z ? (ack0 | err0) : (ack1 | err1)) && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    ra = z ? ack0 : ack1;
    re = z ? err0 : err1;
    rd = z ? dat0 : dat1;
    g  = sbq.pop_front();
    n_checks++;
    if (n !== (z ? 0 : 1))
      $display("FAIL %s_lat: got %0d cycles want %0d", tag, n, z ? 0 : 1);
    else n_pass++;
    n_checks++;
    if (ra !== g.ack)
      $display("FAIL %s_ack: got %b want %b", tag, ra, g.ack);
    else n_pass++;
    n_checks++;
    if (re !== g.err)
      $display("FAIL %s_err: got %b want %b", tag, re, g.err);
    else n_pass++;
    n_checks++;
    if (rd !== g.dat)
      $display("FAIL %s_dat: got %h want %h", tag, rd, g.dat);
    else n_pass++;
    cyc0 = 1'b0;
    cyc1 = 1'b0;
    @(posedge clk); #1;
    rd = z ? dat0 : dat1;
    n_checks++;
    if ({(z ? ack0 : ack1), (z ? err0 : err1), rd} !== 34'd0)
      $display("FAIL %s_post: got ack/err/dat %b%b %h want 00 0",
               tag, z ? ack0 : ack1, z ? err0 : err1, rd);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc1 = 1'b1;
    stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ack1, err1, dat1} !== 34'd0)
      $display("FAIL reset_ws1: got %b%b %h want 00 0", ack1, err1, dat1);
    else n_pass++;
    n_checks++;
    if ({ack0, err0, dat0} !== 34'd0)
      $display("FAIL reset_ws0: got %b%b %h want 00 0", ack0, err0, dat0);
    else n_pass++;
    cyc1 = 1'b0;
    stb = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_xfer(0, 1, 30'h001, 32'hDEADBEEF, 4'hF, "wr1");
    do_xfer(0, 0, 30'h001, 32'h0, 4'hF, "rd1");
    do_xfer(0, 1, 30'h000, 32'h0BADF00D, 4'hF, "wr0");
    do_xfer(0, 1, 30'h002, 32'h11112222, 4'hF, "wr2");
    do_xfer(0, 1, 30'h003, 32'h33334444, 4'hF, "wr3");
    do_xfer(0, 1, 30'h3FF, 32'hCAFEF00D, 4'hF, "wrtop");
    do_xfer(0, 0, 30'h3FF, 32'h0, 4'h0, "rdtop");
  endtask

  task automatic test_byte_lanes();
    do_xfer(0, 1, 30'h001, 32'h000000AF, 4'b0001, "wrb0");
    do_xfer(0, 0, 30'h001, 32'h0, 4'h1, "rdb0");
    do_xfer(0, 1, 30'h001, 32'hAABBCCDD, 4'b1010, "wrb13");
    do_xfer(0, 0, 30'h001, 32'h0, 4'h0, "rdb13");
    do_xfer(0, 1, 30'h001, 32'h55555555, 4'b0000, "wrsel0");
    do_xfer(0, 0, 30'h001, 32'h0, 4'hF, "rdsel0");
  endtask

  task automatic test_out_of_range();
    do_xfer(0, 1, 30'h400, 32'h99999999, 4'hF, "oor_wr");
    do_xfer(0, 0, 30'h400, 32'h0, 4'hF, "oor_rd");
    do_xfer(0, 1, 30'h2000_0000, 32'h77777777, 4'hF, "oor_hi");
    do_xfer(0, 0, 30'h000, 32'h0, 4'hF, "oor_chk0");
  endtask

  task automatic test_abort();
    adr  = 30'h002;
    wdat = 32'h12345678;
    sel  = 4'hF;
    we_s = 1'b1;
    stb  = 1'b1;
    cyc1 = 1'b1;
    @(posedge clk); #1;
    cyc1 = 1'b0;
    stb  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({ack1, err1} !== 2'b00)
        $display("FAIL abort_resp%0d: got %b%b want 00", i, ack1, err1);
      else n_pass++;
    end
    do_xfer(0, 0, 30'h002, 32'h0, 4'hF, "abort_rd");
  endtask

  task automatic test_reset_mid();
    adr  = 30'h003;
    wdat = 32'hFFFF0000;
    sel  = 4'hF;
    we_s = 1'b1;
    stb  = 1'b1;
    cyc1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ack1, err1, dat1} !== 34'd0)
      $display("FAIL rstmid_out: got %b%b %h want 00 0", ack1, err1, dat1);
    else n_pass++;
    // Read request held across reset release.
    we_s = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ack1 !== 1'b0)
      $display("FAIL rsthold_inrst: got %b want 0", ack1);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ack1 !== 1'b0)
      $display("FAIL rsthold_wait: got %b want 0", ack1);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (ack1 !== 1'b1 || dat1 !== m1[3])
      $display("FAIL rsthold_resp: got %b %h want 1 %h", ack1, dat1, m1[3]);
    else n_pass++;
    cyc1 = 1'b0;
    stb  = 1'b0;
    @(posedge clk); #1;
    do_xfer(0, 0, 30'h003, 32'h0, 4'hF, "rstmid_rd");
  endtask

  task automatic test_no_cyc();
    adr  = 30'h001;
    we_s = 1'b0;
    stb  = 1'b1;
    cyc1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({ack1, err1} !== 2'b00)
        $display("FAIL nocyc%0d: got %b%b want 00", i, ack1, err1);
      else n_pass++;
    end
    stb = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_xfer(1, 1, 30'h001, 32'hA1A2A3A4, 4'hF, "z_wr1");
    do_xfer(1, 1, 30'h002, 32'hB1B2B3B4, 4'hF, "z_wr2");
    do_xfer(1, 0, 30'h001, 32'h0, 4'hF, "z_rd1");
    do_xfer(1, 1, 30'h002, 32'h000000C5, 4'b0001, "z_wrb");
    do_xfer(1, 0, 30'h400, 32'h0, 4'hF, "z_oor");
  endtask

  task automatic test_back_to_back();
    adr  = 30'h001;
    we_s = 1'b0;
    sel  = 4'hF;
    stb  = 1'b1;
    cyc0 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ack0 !== 1'b1 || dat0 !== m0[1])
      $display("FAIL b2b_first: got %b %h want 1 %h", ack0, dat0, m0[1]);
    else n_pass++;
    adr = 30'h002;
    @(posedge clk); #1;
    n_checks++;
    if ({ack0, err0, dat0} !== 34'd0)
      $display("FAIL b2b_gap: got %b%b %h want 00 0", ack0, err0, dat0);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (ack0 !== 1'b1 || dat0 !== m0[2])
      $display("FAIL b2b_second: got %b %h want 1 %h", ack0, dat0, m0[2]);
    else n_pass++;
    cyc0 = 1'b0;
    stb  = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_no_cyc();
    test_zero_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
